// File: rtl/uart_decoder_pkg.sv
// rtl/uart_decoder_pkg.sv - shared command-field positions, packet sizing and state encoding
package uart_decoder_pkg;

  localparam int SEL_LSB   = 0;
  localparam int SEL_MSB   = 3;
  localparam int MODE_BIT  = 4;
  localparam int START_BIT = 5;
  localparam int STOP_BIT  = 6;

  localparam int BYTE_BITS = 8;

  // one command byte followed by two patterns of data_bit/8 bytes each
  function automatic int pack_num(input int data_bit);
    return 2 * (data_bit / BYTE_BITS) + 1;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

endpackage

// File: rtl/uart_decoder_if.sv
// rtl/uart_decoder_if.sv - receiver byte strobe in, decoded pattern/command fields out
interface uart_decoder_if #(
  parameter int DATA_BIT = 32
);

  logic [7:0]          i_data;
  logic                i_rx_done_tick;
  logic [DATA_BIT-1:0] o_output_pattern;
  logic [DATA_BIT-1:0] o_freq_pattern;
  logic [3:0]          o_sel_out;
  logic                o_mode;
  logic                o_start;
  logic                o_stop;
  logic                o_done_tick;

  modport master (
    input  i_data, i_rx_done_tick,
    output o_output_pattern, o_freq_pattern, o_sel_out,
           o_mode, o_start, o_stop, o_done_tick
  );

  modport slave (
    output i_data, i_rx_done_tick,
    input  o_output_pattern, o_freq_pattern, o_sel_out,
           o_mode, o_start, o_stop, o_done_tick
  );

endinterface

// File: rtl/uart_decoder.sv
// rtl/uart_decoder.sv - collects a fixed-length UART packet and commits it atomically to the outputs
module uart_decoder
  import uart_decoder_pkg::*;
#(
  parameter int DATA_BIT = 32,
  parameter int PACK_NUM = pack_num(DATA_BIT)
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_decoder_if.master  bus
);

  localparam int NB    = DATA_BIT / 8;
  localparam int CNT_W = $clog2(PACK_NUM);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PACK_NUM - 1);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [6:0]          r_cmd;
  logic [DATA_BIT-1:0] r_out_stage;
  logic [DATA_BIT-1:0] r_freq_stage;

  logic [DATA_BIT-1:0] r_output_pattern;
  logic [DATA_BIT-1:0] r_freq_pattern;
  logic [3:0]          r_sel_out;
  logic                r_mode;
  logic                r_start;
  logic                r_stop;
  logic                r_done_tick;

  logic [6:0]          w_cmd;
  logic [DATA_BIT-1:0] w_out;
  logic [DATA_BIT-1:0] w_freq;
  logic                w_last;

  // staging with the current byte merged in, so the final byte commits in the same edge
  always_comb begin
    w_cmd  = r_cmd;
    w_out  = r_out_stage;
    w_freq = r_freq_stage;
    if (r_state == IDLE) begin
      w_cmd = bus.i_data[6:0];
    end
    for (int b = 0; b < NB; b++) begin
      if (r_cnt == CNT_W'(b + 1))      w_out[b*8 +: 8]  = bus.i_data;
      if (r_cnt == CNT_W'(b + 1 + NB)) w_freq[b*8 +: 8] = bus.i_data;
    end
  end

  assign w_last = bus.i_rx_done_tick && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= IDLE;
      r_cnt            <= '0;
      r_cmd            <= '0;
      r_out_stage      <= '0;
      r_freq_stage     <= '0;
      r_output_pattern <= '0;
      r_freq_pattern   <= '0;
      r_sel_out        <= '0;
      r_mode           <= 1'b0;
      r_start          <= 1'b0;
      r_stop           <= 1'b0;
      r_done_tick      <= 1'b0;
    end else begin
      r_done_tick <= 1'b0;
      r_start     <= 1'b0;
      r_stop      <= 1'b0;
      if (bus.i_rx_done_tick) begin
        r_cmd        <= w_cmd;
        r_out_stage  <= w_out;
        r_freq_stage <= w_freq;
        if (w_last) begin
          r_cnt            <= '0;
          r_state          <= IDLE;
          r_output_pattern <= w_out;
          r_freq_pattern   <= w_freq;
          r_sel_out        <= w_cmd[SEL_MSB:SEL_LSB];
          r_mode           <= w_cmd[MODE_BIT];
          r_start          <= w_cmd[START_BIT];
          r_stop           <= w_cmd[STOP_BIT];
          r_done_tick      <= 1'b1;
        end else begin
          r_cnt   <= r_cnt + 1'b1;
          r_state <= RECV;
        end
      end
    end
  end

  assign bus.o_output_pattern = r_output_pattern;
  assign bus.o_freq_pattern   = r_freq_pattern;
  assign bus.o_sel_out        = r_sel_out;
  assign bus.o_mode           = r_mode;
  assign bus.o_start          = r_start;
  assign bus.o_stop           = r_stop;
  assign bus.o_done_tick      = r_done_tick;

endmodule

// File: tb/tb_uart_decoder.sv
// tb/tb_uart_decoder.sv - directed and randomized packet stimulus against a byte-array reference model
module tb_uart_decoder;

  localparam int DATA_BIT = 32;
  localparam int NB       = DATA_BIT / 8;
  localparam int PACK     = 2 * NB + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_decoder_if #(.DATA_BIT(DATA_BIT)) bus ();

  uart_decoder #(.DATA_BIT(DATA_BIT), .PACK_NUM(PACK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]          mb [PACK];
  int                  mcnt;
  logic [DATA_BIT-1:0] e_out, e_freq;
  logic [3:0]          e_sel;
  logic                e_mode, e_start, e_stop, e_done;

  task automatic chk(input string tag, input logic [DATA_BIT-1:0] obs, input logic [DATA_BIT-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " done"},  DATA_BIT'(bus.o_done_tick), DATA_BIT'(e_done));
    chk({tag, " start"}, DATA_BIT'(bus.o_start),     DATA_BIT'(e_start));
    chk({tag, " stop"},  DATA_BIT'(bus.o_stop),      DATA_BIT'(e_stop));
    chk({tag, " mode"},  DATA_BIT'(bus.o_mode),      DATA_BIT'(e_mode));
    chk({tag, " sel"},   DATA_BIT'(bus.o_sel_out),   DATA_BIT'(e_sel));
    chk({tag, " outp"},  bus.o_output_pattern,       e_out);
    chk({tag, " freq"},  bus.o_freq_pattern,         e_freq);
  endtask

  task automatic model_clear();
    mcnt = 0;
    e_out = '0; e_freq = '0; e_sel = '0;
    e_mode = 0; e_start = 0; e_stop = 0; e_done = 0;
  endtask

  // one clock: drive at the falling edge, check at the next falling edge
  task automatic step(input logic tick, input logic [7:0] b, input string tag);
    bus.i_rx_done_tick = tick;
    bus.i_data         = tick ? b : 8'($urandom);
    @(negedge clk);
    e_done = 0; e_start = 0; e_stop = 0;
    if (tick) begin
      mb[mcnt] = b;
      mcnt++;
      if (mcnt == PACK) begin
        mcnt = 0;
        e_done  = 1;
        e_sel   = mb[0][3:0];
        e_mode  = mb[0][4];
        e_start = mb[0][5];
        e_stop  = mb[0][6];
        for (int i = 0; i < NB; i++) begin
          e_out[i*8 +: 8]  = mb[1 + i];
          e_freq[i*8 +: 8] = mb[1 + NB + i];
        end
      end
    end
    check_all(tag);
  endtask

  initial begin
    bus.i_data = '0;
    bus.i_rx_done_tick = 1'b0;
    model_clear();

    repeat (3) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 8'h00, "post_reset_idle");

    for (int i = 1; i <= 9; i++) step(1, 8'(i), "pkt1");
    chk("pkt1 outp const", bus.o_output_pattern, 32'h05040302);
    chk("pkt1 freq const", bus.o_freq_pattern,   32'h09080706);
    for (int i = 10; i <= 18; i++) step(1, 8'(i), "pkt2");
    chk("pkt2 sel const",  DATA_BIT'(bus.o_sel_out), 32'hA);
    chk("pkt2 outp const", bus.o_output_pattern, 32'h0E0D0C0B);
    chk("pkt2 freq const", bus.o_freq_pattern,   32'h1211100F);

    step(1, 8'h13, "partial");
    for (int i = 0; i < 4; i++) step(0, 8'h00, "partial_wait");

    // finish the partial packet to realign, then a start+stop command
    for (int i = 0; i < PACK - 1; i++) step(1, 8'($urandom), "realign");
    step(1, 8'h70, "ss_cmd");
    for (int i = 0; i < PACK - 1; i++) step(1, 8'($urandom), "ss_pkt");
    chk("ss start const", DATA_BIT'(bus.o_start), 32'h1);
    chk("ss stop const",  DATA_BIT'(bus.o_stop),  32'h1);
    chk("ss mode const",  DATA_BIT'(bus.o_mode),  32'h1);
    step(0, 8'h00, "ss_deassert");

    for (int p = 0; p < 20; p++) begin
      for (int i = 0; i < PACK; i++) begin
        if ($urandom_range(3) == 0) step(0, 8'h00, "rand_gap");
        step(1, 8'($urandom), "rand");
      end
    end

    for (int i = 0; i < 4; i++) step(1, 8'($urandom), "pre_rst");
    rst_n = 1'b0;
    bus.i_rx_done_tick = 1'b0;
    @(negedge clk);
    model_clear();
    check_all("mid_reset");
    rst_n = 1'b1;
    step(0, 8'h00, "post_mid_reset");
    step(1, 8'h03, "after_rst");
    for (int i = 0; i < PACK - 1; i++) step(1, 8'($urandom), "after_rst");
    chk("after_rst sel const", DATA_BIT'(bus.o_sel_out), 32'h3);
    step(0, 8'h00, "final_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
